// File: rtl/bicubic_pkg.sv
// Shared types and helpers for the bicubic window sequencer.
// Holds the state encoding, the window/fetch geometry and the border clamp.
package bicubic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LAND,
    ST_WIN,
    ST_DONE
  } state_t;

  localparam int WIN_TAPS  = 4;
  localparam int FETCH_LEN = 4;

  // Border replication: negative coordinates pin to 0, overshoot pins to the last pixel.
  function automatic int clamp_coord(input int v, input int limit);
    int r;
    r = v;
    if (v < 0) r = 0;
    else if (v >= limit) r = limit - 1;
    return r;
  endfunction

endpackage

// File: rtl/bicubic_window_ctrl.sv
// Walks the source image band by band, fills the 4x4 column-shift window buffer
// and hands each complete neighbourhood to the interpolation core via valid/ready.
module bicubic_window_ctrl
  import bicubic_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_row,
  output logic [AW-1:0] rd_col,
  input  logic [7:0]    rd_data,
  output logic          buf_act,
  output logic [7:0]    buf_in,
  output logic          win_vld,
  input  logic          win_rdy,
  output logic [AW-1:0] win_x,
  output logic [AW-1:0] win_y
);

  localparam logic [AW-1:0]   WIN_LAST = AW'(WIN_TAPS - 1);
  localparam logic [AW-1:0]   J_LAST   = AW'(IMG_W + 2);
  localparam logic [AW-1:0]   Y_LAST   = AW'(IMG_H - 1);
  localparam logic [1:0]      K_LAST   = 2'(FETCH_LEN - 1);
  localparam logic [AW-1:0]   STEP     = AW'(1);
  localparam logic signed [AW:0] ONE   = (AW+1)'(1);

  state_t        state, state_n;
  logic [AW-1:0] y_cnt, y_n;
  logic [AW-1:0] j_cnt, j_n;
  logic [1:0]    k_cnt, k_n;

  logic signed [AW:0] row_raw;
  logic signed [AW:0] col_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      y_cnt   <= '0;
      j_cnt   <= '0;
      k_cnt   <= '0;
      buf_act <= 1'b0;
    end else begin
      state   <= state_n;
      y_cnt   <= y_n;
      j_cnt   <= j_n;
      k_cnt   <= k_n;
      buf_act <= (state == ST_FETCH);
    end
  end

  always_comb begin
    state_n = state;
    y_n     = y_cnt;
    j_n     = j_cnt;
    k_n     = k_cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_FETCH;
          y_n     = '0;
          j_n     = '0;
          k_n     = '0;
        end
      end
      ST_FETCH: begin
        if (k_cnt == K_LAST) begin
          state_n = ST_LAND;
          k_n     = '0;
        end else begin
          k_n = k_cnt + 2'd1;
        end
      end
      ST_LAND: begin
        if (j_cnt >= WIN_LAST) begin
          state_n = ST_WIN;
        end else begin
          j_n     = j_cnt + STEP;
          state_n = ST_FETCH;
        end
      end
      // Holding here while the core stalls keeps the buffer frozen under the pending window.
      ST_WIN: begin
        if (win_rdy) begin
          if (j_cnt < J_LAST) begin
            j_n     = j_cnt + STEP;
            state_n = ST_FETCH;
          end else begin
            j_n = '0;
            if (y_cnt == Y_LAST) begin
              y_n     = '0;
              state_n = ST_DONE;
            end else begin
              y_n     = y_cnt + STEP;
              state_n = ST_FETCH;
            end
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign row_raw = $signed({1'b0, y_cnt}) + $signed({{(AW-1){1'b0}}, k_cnt}) - ONE;
  assign col_raw = $signed({1'b0, j_cnt}) - ONE;

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign rd_en   = (state == ST_FETCH);
  assign rd_row  = rd_en ? AW'(clamp_coord(int'(row_raw), IMG_H)) : '0;
  assign rd_col  = rd_en ? AW'(clamp_coord(int'(col_raw), IMG_W)) : '0;
  assign buf_in  = rd_data;
  assign win_vld = (state == ST_WIN);
  assign win_x   = win_vld ? (j_cnt - WIN_LAST) : '0;
  assign win_y   = win_vld ? y_cnt : '0;

endmodule

// File: tb/tb_bicubic_window_ctrl.sv
// Directed bench for bicubic_window_ctrl on a 4x4 image: timing, addressing,
// backpressure, mid-frame reset and stray start pulses.
module tb_bicubic_window_ctrl;

  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          win_rdy = 1'b1;
  logic [7:0]    rd_data = 8'd0;
  logic          busy, done, rd_en, buf_act, win_vld;
  logic [AW-1:0] rd_row, rd_col, win_x, win_y;
  logic [7:0]    buf_in;

  int checks = 0;
  int passed = 0;
  int cyc, done_cnt, act_cnt;
  int wx_q[$], wy_q[$], rr_q[$], rc_q[$], bin_q[$];

  bicubic_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .buf_act(buf_act), .buf_in(buf_in), .win_vld(win_vld), .win_rdy(win_rdy),
    .win_x(win_x), .win_y(win_y)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(r * 16 + c);
  endfunction

  // Source memory: one-cycle read latency.
  always @(posedge clk) if (rd_en) rd_data <= pix(int'(rd_row), int'(rd_col));

  task automatic clear_obs();
    cyc = 0; done_cnt = 0; act_cnt = 0;
    wx_q.delete(); wy_q.delete(); rr_q.delete(); rc_q.delete(); bin_q.delete();
  endtask

  task automatic tick();
    @(posedge clk); #1; cyc++;
    if (win_vld && win_rdy) begin wx_q.push_back(int'(win_x)); wy_q.push_back(int'(win_y)); end
    if (done) done_cnt++;
    if (buf_act) begin act_cnt++; bin_q.push_back(int'(buf_in)); end
    if (rd_en) begin rr_q.push_back(int'(rd_row)); rc_q.push_back(int'(rd_col)); end
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; win_rdy = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_frame();
    clear_obs();
    @(negedge clk); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, rd_en, buf_act, win_vld} !== 5'b0) $display("[TB] FAIL reset_flags: got %b want 00000", {busy, done, rd_en, buf_act, win_vld}); else passed++;
    checks++;
    if ({rd_row, rd_col, win_x, win_y} !== '0) $display("[TB] FAIL reset_coords: got %0d,%0d,%0d,%0d want 0,0,0,0", rd_row, rd_col, win_x, win_y); else passed++;
  endtask

  task automatic test_full_frame();
    int exp_row[16] = '{0,0,1,2, 0,0,1,2, 0,0,1,2, 0,0,1,2};
    int exp_col[16] = '{0,0,0,0, 0,0,0,0, 1,1,1,1, 2,2,2,2};
    int bot_row[4]  = '{2,3,3,3};
    int ec, idx;
    do_reset();
    start_frame();
    checks++;
    if ({busy, rd_en} !== 2'b11) $display("[TB] FAIL start_busy: got %b want 11", {busy, rd_en}); else passed++;
    while (!win_vld && cyc < 100) tick();
    checks++;
    if (cyc != 21) $display("[TB] FAIL first_win_cycle: got %0d want 21", cyc); else passed++;
    checks++;
    if ({win_x, win_y} !== '0) $display("[TB] FAIL first_win_xy: got %0d,%0d want 0,0", win_x, win_y); else passed++;
    while (!done && cyc < 400) tick();
    checks++;
    if (cyc != 4 * 39 + 1) $display("[TB] FAIL done_cycle: got %0d want %0d", cyc, 4 * 39 + 1); else passed++;
    repeat (3) tick();
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) $display("[TB] FAIL done_once: got %0d pulses busy=%b want 1 pulse busy=0", done_cnt, busy); else passed++;
    checks++;
    if (wx_q.size() != IMG_W * IMG_H) $display("[TB] FAIL window_count: got %0d want %0d", wx_q.size(), IMG_W * IMG_H); else passed++;
    if (wx_q.size() == IMG_W * IMG_H) begin
      for (int i = 0; i < IMG_W * IMG_H; i++) begin
        checks++;
        if (wx_q[i] != i % IMG_W || wy_q[i] != i / IMG_W) $display("[TB] FAIL raster_%0d: got (%0d,%0d) want (%0d,%0d)", i, wx_q[i], wy_q[i], i % IMG_W, i / IMG_W); else passed++;
      end
    end
    checks++;
    if (rr_q.size() != 112 || act_cnt != 112) $display("[TB] FAIL read_count: got reads=%0d acts=%0d want 112,112", rr_q.size(), act_cnt); else passed++;
    if (rr_q.size() >= 112 && bin_q.size() >= 16) begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (rr_q[i] != exp_row[i] || rc_q[i] != exp_col[i]) $display("[TB] FAIL band0_addr_%0d: got (%0d,%0d) want (%0d,%0d)", i, rr_q[i], rc_q[i], exp_row[i], exp_col[i]); else passed++;
        checks++;
        if (bin_q[i] != int'(pix(exp_row[i], exp_col[i]))) $display("[TB] FAIL buf_in_%0d: got %0h want %0h", i, bin_q[i], pix(exp_row[i], exp_col[i])); else passed++;
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rr_q[24 + k] != exp_row[k] || rc_q[24 + k] != 3) $display("[TB] FAIL band0_last_col_%0d: got (%0d,%0d) want (%0d,3)", k, rr_q[24 + k], rc_q[24 + k], exp_row[k]); else passed++;
      end
      for (int c = 0; c < 7; c++) begin
        ec = (c == 0) ? 0 : ((c > 4) ? 3 : c - 1);
        for (int k = 0; k < 4; k++) begin
          idx = 84 + c * 4 + k;
          checks++;
          if (rr_q[idx] != bot_row[k] || rc_q[idx] != ec) $display("[TB] FAIL band3_addr_c%0d_k%0d: got (%0d,%0d) want (%0d,%0d)", c, k, rr_q[idx], rc_q[idx], bot_row[k], ec); else passed++;
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    win_rdy = 1'b0;
    start_frame();
    while (!win_vld && cyc < 100) tick();
    checks++;
    if (cyc != 21) $display("[TB] FAIL bp_first_win_cycle: got %0d want 21", cyc); else passed++;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({win_vld, rd_en, buf_act} !== 3'b100 || {win_x, win_y} !== '0) $display("[TB] FAIL bp_hold_%0d: got vld/rd/act=%b xy=%0d,%0d want 100 xy=0,0", i, {win_vld, rd_en, buf_act}, win_x, win_y); else passed++;
    end
    @(negedge clk); win_rdy = 1'b1;
    tick();
    checks++;
    if ({win_vld, rd_en} !== 2'b01 || rd_col !== AW'(3)) $display("[TB] FAIL bp_resume: got vld/rd=%b col=%0d want 01 col=3", {win_vld, rd_en}, rd_col); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    start_frame();
    tick();
    tick();
    checks++;
    if (rd_en !== 1'b1 || rd_row !== AW'(1)) $display("[TB] FAIL mid_precond: got rd_en=%b row=%0d want 1,1", rd_en, rd_row); else passed++;
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, rd_en, buf_act, win_vld, rd_row, rd_col, win_x, win_y} !== '0) $display("[TB] FAIL mid_reset_outputs: got busy=%b rd_en=%b act=%b row=%0d col=%0d want all 0", busy, rd_en, buf_act, rd_row, rd_col); else passed++;
    @(negedge clk); rst = 1'b1;
    start_frame();
    while (!win_vld && cyc < 100) tick();
    checks++;
    if (cyc != 21 || {win_x, win_y} !== '0) $display("[TB] FAIL mid_restart_win: got cycle %0d xy=%0d,%0d want 21 xy=0,0", cyc, win_x, win_y); else passed++;
  endtask

  task automatic test_start_while_busy();
    do_reset();
    start_frame();
    while (!done && cyc < 400) begin
      if (cyc == 1 || cyc == 50 || cyc == 100) start = 1'b1;
      tick();
      start = 1'b0;
    end
    checks++;
    if (cyc != 157) $display("[TB] FAIL busy_start_done_cycle: got %0d want 157", cyc); else passed++;
    repeat (3) tick();
    checks++;
    if (wx_q.size() != IMG_W * IMG_H || done_cnt != 1) $display("[TB] FAIL busy_start_counts: got windows=%0d done=%0d want 16,1", wx_q.size(), done_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_reset_mid_frame();
    test_start_while_busy();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
